vx_dcr_queue: RTL
=================

// Module: vx_dcr_queue
// PURPOSE
//  Parametrised DCR write queue between the Piton-side DCR decoder and the Vortex DCR bus.
//  Single clock domain; no input synchroniser; the producer uses a valid/ready handshake.
//  Configurable depth, commit-gated release (HOLD_MODE), flush, and occupancy status.
//  Writes issue in order, one per cycle max, from a registered output stage gated by dcr_busy.
// PARAMETERS
//  VX_DCR_ADDR_WIDTH  8   DCR address width
//  VX_DCR_DATA_WIDTH  32  DCR data width
//  DEPTH              8   queue entries; power of two, >=2; PTR_W=$clog2(DEPTH) (localparam)
//  HOLD_MODE          0   0: entries issue as soon as queued; 1: entries issue only after commit
// PORTS
//  clk           in   1        clock
//  rst_n         in   1        asynchronous active-low reset
//  in_valid      in   1        producer has a DCR write
//  in_addr       in   ADDR_W   DCR address
//  in_data       in   DATA_W   DCR data
//  in_ready      out  1        queue accepts; push = in_valid & in_ready
//  commit        in   1        HOLD_MODE=1: release all entries queued so far (incl. same-cycle push)
//  flush         in   1        discard every queued entry not yet issued
//  dcr_busy      in   1        Vortex cannot take a write this cycle
//  dcr_wr_valid  out  1        registered single-cycle write strobe to Vortex
//  dcr_wr_addr   out  ADDR_W   registered write address
//  dcr_wr_data   out  DATA_W   registered write data
//  count         out  PTR_W+1  entries held (wr_ptr - rd_ptr), 0..DEPTH
//  empty         out  1        count==0
//  full          out  1        count==DEPTH
//  idle          out  1        empty & ~dcr_wr_valid
// BEHAVIOUR
//  Reset (rst_n low, async): wr/rd/cmt pointers=0, dcr_wr_valid=0, dcr_wr_addr/data=0,
//   count=0, empty=1, full=0, idle=1. Storage array is not reset.
//  Pointers are PTR_W+1 bits and wrap modulo 2*DEPTH; full = MSBs differ and low bits equal.
//  in_ready = ~full & ~flush (combinational). A push writes mem[wr_ptr] and increments wr_ptr.
//  Commit pointer: HOLD_MODE=0 -> cmt tracks post-push wr_ptr every cycle.
//   HOLD_MODE=1 -> on commit, cmt <= wr_ptr + push; otherwise cmt holds.
//  Releasable = cmt - rd_ptr. Issue cycle: ~flush & ~dcr_busy & releasable!=0 ->
//   next edge: dcr_wr_valid<=1, addr/data<=mem[rd_ptr], rd_ptr++. Otherwise dcr_wr_valid<=0;
//   addr/data hold their last value.
//  dcr_busy is sampled only in the issue cycle; a strobe already registered is not retracted.
//  Back-to-back strobes allowed while ~dcr_busy; the strobe rate is one write per cycle.
//  Latency (HOLD_MODE=0, idle queue, busy=0): push at edge N -> dcr_wr_valid high in cycle N+2.
//  Simultaneous push and issue: both take effect; count unchanged; full frees one slot next cycle.
//  Push into a queue that is full on that cycle is impossible (in_ready=0); no overwrite.
//  flush: rd_ptr<=wr_ptr, cmt<=wr_ptr; same-cycle push blocked; same-cycle commit ignored.
//   The registered strobe from the previous cycle completes normally. No issue in the flush cycle.
//  HOLD_MODE=1 with uncommitted entries: entries sit indefinitely; full blocks producer.
//  Mid-operation reset: the queue and the output strobe clear asynchronously; queued writes are lost.
// TESTING
//  T1 DEPTH=8,H=0: push 3 writes (a=01,d=A0..A2) busy=0 -> 3 strobes in order, first at push+2.
//  T2 push 8 with busy=1 -> full=1, in_ready=0, count=8; 9th held by producer. Busy=0 ->
//     8 strobes back-to-back, then the 9th, wrap of ptr MSB checked, empty=1, idle=1.
//  T3 H=1: push 4, no commit -> no strobe for 20 cycles; commit with 5th push -> exactly 5 strobes.
//  T4 queue 5 and busy=1; flush pulse -> count=0, zero strobes after busy drops; push in flush cycle dropped.
//  T5 toggle busy every cycle with 6 queued -> a strobe only follows a busy=0 cycle; order/data intact.
//  T6 assert rst_n=0 mid-burst (3 left) -> dcr_wr_valid=0 immediately, count=0, no strobes after release.

Source files
------------

// File: rtl/vx_dcr_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : vx_dcr_queue_if
// Brief    : Producer-side handshake, control and Vortex DCR write bus
//            bundled for the DCR write queue.
// Revision : 1.0 - initial release
// ============================================================================
interface vx_dcr_queue_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   // Producer handshake
   logic              in_valid;
   logic [ADDR_W-1:0] in_addr;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;

   // Queue control
   logic              commit;
   logic              flush;

   // Vortex DCR side
   logic              dcr_busy;
   logic              dcr_wr_valid;
   logic [ADDR_W-1:0] dcr_wr_addr;
   logic [DATA_W-1:0] dcr_wr_data;

   // Occupancy status
   logic [CNT_W-1:0]  count;
   logic              empty;
   logic              full;
   logic              idle;

   // Driver / observer of the queue
   modport master (
      output in_valid, in_addr, in_data, commit, flush, dcr_busy,
      input  in_ready, dcr_wr_valid, dcr_wr_addr, dcr_wr_data,
             count, empty, full, idle
   );

   // The queue itself
   modport slave (
      input  in_valid, in_addr, in_data, commit, flush, dcr_busy,
      output in_ready, dcr_wr_valid, dcr_wr_addr, dcr_wr_data,
             count, empty, full, idle
   );
endinterface
`default_nettype wire

// File: rtl/vx_dcr_queue.sv
`default_nettype none
// ============================================================================
// Module   : vx_dcr_queue
// Brief    : In-order DCR write queue between the Piton-side decoder and the
//            Vortex DCR bus. Optional commit-gated release, flush, occupancy
//            status and a registered single-cycle write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module vx_dcr_queue #(
   parameter int VX_DCR_ADDR_WIDTH = 8,
   parameter int VX_DCR_DATA_WIDTH = 32,
   parameter int DEPTH             = 8,
   parameter int HOLD_MODE         = 0
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   vx_dcr_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = VX_DCR_ADDR_WIDTH + VX_DCR_DATA_WIDTH;
   localparam logic [PTR_W:0] c_PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W:0] c_PTR_ZERO = '0;

   // Storage is deliberately left unreset; pointers alone define validity.
   logic [ENT_W-1:0] r_mem [DEPTH];

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PTR_W:0] r_wr_ptr;
   logic [PTR_W:0] r_rd_ptr;
   logic [PTR_W:0] r_cmt_ptr;

   logic [PTR_W:0] w_wr_ptr_nxt;
   logic [PTR_W:0] w_cmt_ptr_nxt;
   logic [PTR_W:0] w_count;
   logic [PTR_W:0] w_releasable;
   logic           w_full;
   logic           w_empty;
   logic           w_push;
   logic           w_issue;

   logic                         r_wr_valid;
   logic [VX_DCR_ADDR_WIDTH-1:0] r_wr_addr;
   logic [VX_DCR_DATA_WIDTH-1:0] r_wr_data;

   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

   // A flush cycle refuses new writes so the flush target is well defined.
   assign bus.in_ready = ~w_full & ~bus.flush;
   assign w_push       = bus.in_valid & ~w_full & ~bus.flush;
   assign w_wr_ptr_nxt = r_wr_ptr + (w_push ? c_PTR_ONE : c_PTR_ZERO);

   // Only entries below the commit pointer may leave the queue.
   assign w_releasable = r_cmt_ptr - r_rd_ptr;
   assign w_issue      = ~bus.flush & ~bus.dcr_busy & (w_releasable != c_PTR_ZERO);

   generate
      if (HOLD_MODE != 0) begin : g_hold
         // Commit releases everything queued so far, including this cycle's push.
         assign w_cmt_ptr_nxt = bus.flush  ? r_wr_ptr     :
                                bus.commit ? w_wr_ptr_nxt : r_cmt_ptr;
      end else begin : g_stream
         // Every queued entry is immediately releasable.
         assign w_cmt_ptr_nxt = bus.flush ? r_wr_ptr : w_wr_ptr_nxt;
      end
   endgenerate

   // Pointer bookkeeping: push, commit tracking, issue and flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_cmt_ptr <= '0;
      end else begin
         r_wr_ptr  <= w_wr_ptr_nxt;
         r_cmt_ptr <= w_cmt_ptr_nxt;
         if (bus.flush) begin
            r_rd_ptr <= r_wr_ptr;
         end else if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
      end
   end

   // Entry storage written on every accepted push.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[PTR_W-1:0]] <= {bus.in_addr, bus.in_data};
      end
   end

   // Registered write stage: one strobe per issue, address/data hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
      end else begin
         r_wr_valid <= w_issue;
         if (w_issue) begin
            {r_wr_addr, r_wr_data} <= r_mem[r_rd_ptr[PTR_W-1:0]];
         end
      end
   end

   assign bus.dcr_wr_valid = r_wr_valid;
   assign bus.dcr_wr_addr  = r_wr_addr;
   assign bus.dcr_wr_data  = r_wr_data;
   assign bus.count        = w_count;
   assign bus.empty        = w_empty;
   assign bus.full         = w_full;
   assign bus.idle         = w_empty & ~r_wr_valid;

endmodule
`default_nettype wire
